uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered UART transmitter: a small byte FIFO feeding an 8N1 (or 8E1) serialiser
// that advances one bit per baud_tick and chains queued frames without idle bits.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       wr_en,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       tx_done,
    output logic [2:0] dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q;
    logic          txd_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    shift_q;
    logic [2:0]    bitcnt_q;
    logic          par_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          wr_ok;
    logic          pop;
    logic [7:0]    head;

    // Flags come straight from the count register, so they never glitch.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

    assign wr_ok = wr_en & ~full;
    assign pop   = baud_tick & ~empty & ((state_q == S_IDLE) | (state_q == S_STOP));

    always_comb begin
        count_d = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= TxD_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (baud_tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!empty) begin
                            shift_q <= head;
                            par_q   <= ^head;
                            txd_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_START;
                        end
                    end
                    S_START: begin
                        txd_q    <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        bitcnt_q <= '0;
                        state_q  <= S_DATA;
                    end
                    S_DATA: begin
                        // bitcnt_q names the data bit currently on the line.
                        if (bitcnt_q == 3'd7) begin
                            if (PARITY_EN) begin
                                txd_q   <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            txd_q    <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        done_q <= 1'b1;
                        if (!empty) begin
                            shift_q <= head;
                            par_q   <= ^head;
                            txd_q   <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign TxD         = txd_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (no parity / even parity) whose serial lines are
// sampled mid-bit and compared against frames built from the byte values alone.
module tb_uart_tx;

    // Inputs change half a cycle after posedge; baud_tick has one owner, the generator.
    // A write is accepted when wr_en=1 and full=0 at a posedge; nothing back-pressures TxD.
    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       tick_en;
    int         div;
    logic       wr0, wr1;
    logic [7:0] d0, d1;
    logic       txd0, busy0, full0, empty0, done0;
    logic       txd1, busy1, full1, empty1, done1;
    logic [2:0] st0, st1;

    int n_tests;
    int n_fail;
    int done_cnt0;
    int done_cnt1;

    logic [10:0] exp_q[$];
    logic [10:0] rx_q[$];

    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr0), .TxD_data(d0),
        .TxD(txd0), .busy(busy0), .full(full0), .empty(empty0), .tx_done(done0),
        .dbg_state_o(st0)
    );

    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr1), .TxD_data(d1),
        .TxD(txd1), .busy(busy1), .full(full1), .empty(empty1), .tx_done(done1),
        .dbg_state_o(st1)
    );

    // ---------------- clock / tick / monitors ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        div = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                baud_tick = (div == 0);
                div = (div == 15) ? 0 : div + 1;
            end else begin
                baud_tick = 1'b0;
                div = 0;
            end
        end
    end

    initial begin
        done_cnt0 = 0;
        done_cnt1 = 0;
        forever begin
            @(negedge clk);
            if (done0 === 1'b1) done_cnt0++;
            if (done1 === 1'b1) done_cnt1++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [10:0] model_frame(input logic [7:0] b, input bit par);
        logic [10:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = (((b >> i) & 8'd1) != 8'd0);
            ones += int'((b >> i) & 8'd1);
        end
        if (par) begin
            f[9]  = (ones % 2) == 1;
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic write_byte(input int sel, input logic [7:0] b);
        if (sel != 0) begin
            wr1 = 1'b1;
            d1  = b;
        end else begin
            wr0 = 1'b1;
            d0  = b;
        end
        cyc();
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    // Finds a start bit, then samples nframes*flen contiguous bit centres.
    task automatic rx_frames(input int sel, input int nframes, input int flen);
        int waited;
        logic [10:0] f;
        waited = 0;
        rx_q.delete();
        while ((((sel != 0) ? txd1 : txd0) !== 1'b0) && waited < 3000) begin
            cyc();
            waited++;
        end
        if (waited >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_start sel=%0d: line stayed high %0d cycles, need a start bit", sel, waited);
            for (int k = 0; k < nframes; k++) rx_q.push_back('x);
            return;
        end
        repeat (7) cyc();
        for (int fr = 0; fr < nframes; fr++) begin
            f = '0;
            for (int b = 0; b < flen; b++) begin
                f[b] = (sel != 0) ? txd1 : txd0;
                repeat (16) cyc();
            end
            rx_q.push_back(f);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) cyc();
        n_tests++; if (txd0 !== 1'b1)   begin n_fail++; $display("FAIL reset_txd got %b need 1", txd0); end
        n_tests++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b need 0", busy0); end
        n_tests++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b need 1", empty0); end
        n_tests++; if (full0 !== 1'b0)  begin n_fail++; $display("FAIL reset_full got %b need 0", full0); end
        n_tests++; if (done0 !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b need 0", done0); end
        n_tests++; if (st0 !== 3'd0 || st1 !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d/%0d need idle 0/0", st0, st1); end
        n_tests++; if (txd1 !== 1'b1 || empty1 !== 1'b1) begin n_fail++; $display("FAIL reset_par_inst got txd=%b empty=%b need 1 1", txd1, empty1); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int base;
        base = done_cnt0;
        tick_en = 1'b1;
        fork
            write_byte(0, 8'h55);
            rx_frames(0, 1, 10);
        join
        n_tests++;
        if (rx_q[0] !== model_frame(8'h55, 1'b0)) begin
            n_fail++; $display("FAIL basic_55 frame got %b need %b", rx_q[0], model_frame(8'h55, 1'b0));
        end
        n_tests++; if (done_cnt0 - base != 1) begin n_fail++; $display("FAIL basic_done got %0d pulses need 1", done_cnt0 - base); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b need 0", busy0); end
        n_tests++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b need 1", empty0); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = done_cnt0;
        exp_q.delete();
        exp_q.push_back(model_frame(8'hA3, 1'b0));
        exp_q.push_back(model_frame(8'h0F, 1'b0));
        fork
            begin write_byte(0, 8'hA3); write_byte(0, 8'h0F); end
            rx_frames(0, 2, 10);
        join
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_frame%0d got %b need %b", i, rx_q[i], exp_q[i]); end
        end
        n_tests++; if (done_cnt0 - base != 2) begin n_fail++; $display("FAIL b2b_done got %0d pulses need 2", done_cnt0 - base); end
        n_tests++; if (empty0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got empty=%b busy=%b need 1 0", empty0, busy0); end
    endtask

    task automatic test_random();
        int n;
        int base;
        logic [7:0] bytes [4];
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 4);
            base = done_cnt0;
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                bytes[i] = 8'($urandom_range(0, 255));
                exp_q.push_back(model_frame(bytes[i], 1'b0));
            end
            fork
                for (int i = 0; i < n; i++) write_byte(0, bytes[i]);
                rx_frames(0, n, 10);
            join
            for (int i = 0; i < n; i++) begin
                n_tests++;
                if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_r%0d_f%0d got %b need %b", r, i, rx_q[i], exp_q[i]); end
            end
            n_tests++; if (done_cnt0 - base != n) begin n_fail++; $display("FAIL rand_r%0d_done got %0d need %0d", r, done_cnt0 - base, n); end
        end
    endtask

    task automatic test_overflow();
        int base;
        int lows;
        logic [7:0] bytes [5];
        tick_en = 1'b0;
        repeat (3) cyc();
        base = done_cnt0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            if (i < 4) exp_q.push_back(model_frame(bytes[i], 1'b0));
        end
        for (int i = 0; i < 4; i++) write_byte(0, bytes[i]);
        n_tests++; if (full0 !== 1'b1) begin n_fail++; $display("FAIL ovf_full4 got %b need 1", full0); end
        write_byte(0, bytes[4]);
        n_tests++; if (full0 !== 1'b1 || empty0 !== 1'b0) begin n_fail++; $display("FAIL ovf_full5 got full=%b empty=%b need 1 0", full0, empty0); end
        n_tests++; if (txd0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL ovf_no_tick got txd=%b busy=%b need 1 0", txd0, busy0); end
        tick_en = 1'b1;
        rx_frames(0, 4, 10);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_frame%0d got %b need %b", i, rx_q[i], exp_q[i]); end
        end
        lows = 0;
        repeat (60) begin
            if (txd0 !== 1'b1) lows++;
            cyc();
        end
        n_tests++; if (lows != 0) begin n_fail++; $display("FAIL ovf_dropped got %0d low cycles need 0", lows); end
        n_tests++; if (done_cnt0 - base != 4) begin n_fail++; $display("FAIL ovf_done got %0d need 4", done_cnt0 - base); end
        n_tests++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b need 1", empty0); end
    endtask

    task automatic test_parity();
        int base;
        logic [7:0] rb;
        base = done_cnt1;
        rb = 8'($urandom_range(0, 255));
        exp_q.delete();
        exp_q.push_back(model_frame(8'h07, 1'b1));
        exp_q.push_back(model_frame(8'h03, 1'b1));
        exp_q.push_back(model_frame(rb, 1'b1));
        fork
            begin write_byte(1, 8'h07); write_byte(1, 8'h03); write_byte(1, rb); end
            rx_frames(1, 3, 11);
        join
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL par_frame%0d got %b need %b", i, rx_q[i], exp_q[i]); end
        end
        n_tests++; if (rx_q[0][9] !== 1'b1) begin n_fail++; $display("FAIL par_bit_07 got %b need 1", rx_q[0][9]); end
        n_tests++; if (rx_q[1][9] !== 1'b0) begin n_fail++; $display("FAIL par_bit_03 got %b need 0", rx_q[1][9]); end
        n_tests++; if (done_cnt1 - base != 3) begin n_fail++; $display("FAIL par_done got %0d need 3", done_cnt1 - base); end
    endtask

    task automatic test_idle_write();
        int waited;
        int lows;
        int base;
        tick_en = 1'b1;
        waited = 0;
        while (baud_tick !== 1'b1 && waited < 40) begin
            cyc();
            waited++;
        end
        n_tests++; if (baud_tick !== 1'b1) begin n_fail++; $display("FAIL idle_tick_seen got %b need 1", baud_tick); end
        base = done_cnt0;
        wr0 = 1'b1;
        d0  = 8'h5A;
        cyc();
        wr0 = 1'b0;
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            if (txd0 !== 1'b1) lows++;
            cyc();
        end
        n_tests++; if (lows != 0) begin n_fail++; $display("FAIL idle_write_early got %0d low cycles need 0", lows); end
        n_tests++; if (txd0 !== 1'b0) begin n_fail++; $display("FAIL idle_write_start got %b need 0", txd0); end
        repeat (165) cyc();
        n_tests++; if (done_cnt0 - base != 1 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL idle_write_done got %0d pulses busy=%b need 1 0", done_cnt0 - base, busy0);
        end
    endtask

    task automatic test_reset_midframe();
        int waited;
        int lows;
        int base;
        logic [7:0] rb;
        tick_en = 1'b1;
        base = done_cnt0;
        write_byte(0, 8'hFF);
        write_byte(0, 8'h12);
        waited = 0;
        while (txd0 !== 1'b0 && waited < 100) begin
            cyc();
            waited++;
        end
        repeat (4 * 16 + 8) cyc();
        n_tests++; if (busy0 !== 1'b1 || empty0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre got busy=%b empty=%b need 1 0", busy0, empty0); end
        rst = 1'b0;
        #1;
        n_tests++; if (txd0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd got %b need 1", txd0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b need 0", busy0); end
        n_tests++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got %b need 1", empty0); end
        repeat (3) cyc();
        rst = 1'b1;
        lows = 0;
        repeat (200) begin
            if (txd0 !== 1'b1) lows++;
            cyc();
        end
        n_tests++; if (lows != 0) begin n_fail++; $display("FAIL rstmid_flushed got %0d low cycles need 0", lows); end
        n_tests++; if (done_cnt0 - base != 0) begin n_fail++; $display("FAIL rstmid_done got %0d pulses need 0", done_cnt0 - base); end
        rb = 8'($urandom_range(0, 255));
        fork
            write_byte(0, rb);
            rx_frames(0, 1, 10);
        join
        n_tests++; if (rx_q[0] !== model_frame(rb, 1'b0)) begin n_fail++; $display("FAIL rstmid_after got %b need %b", rx_q[0], model_frame(rb, 1'b0)); end
        n_tests++; if (done_cnt0 - base != 1) begin n_fail++; $display("FAIL rstmid_after_done got %0d need 1", done_cnt0 - base); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        tick_en = 1'b0;
        wr0 = 1'b0; wr1 = 1'b0;
        d0  = '0;   d1  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_overflow();
        test_parity();
        test_idle_write();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
